// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants and types for the off-chip data memory model.
//   LINE_W       : cache line width in bits (32 bytes)
//   OFFSET_BITS  : byte-offset bits inside a line, ignored by the memory
//   DEF_*        : default values for the top-level parameters
//   dmem_state_t : request FSM states
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;
  localparam int DEF_LATENCY = 10;
  localparam int DEF_DEPTH   = 512;
  localparam int DEF_ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/offchip_data_memory_if.sv
// -----------------------------------------------------------------------------
// offchip_data_memory_if
// Line-request bus between the dcache controller (master) and the off-chip
// data memory (slave).
//   enable_i : request valid
//   write_i  : 1 = line write, 0 = line read
//   addr_i   : byte address, low OFFSET_BITS ignored
//   data_i   : write line
//   ack_o    : one-cycle completion pulse
//   data_o   : read line, held until the next read completes
//   busy_o   : request in flight
// -----------------------------------------------------------------------------
interface offchip_data_memory_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);

  logic              enable_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic              busy_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o, busy_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o, busy_o
  );

endinterface

// File: rtl/dmem_delay_counter.sv
// -----------------------------------------------------------------------------
// dmem_delay_counter
// Counts the wait cycles of one memory request.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   start_i : clear the count (request accepted)
//   en_i    : count while the request is waiting
//   done_o  : high while counting and the count equals LATENCY-1; the owner
//             leaves its wait state on the edge that sees this
// -----------------------------------------------------------------------------
module dmem_delay_counter
  import dmem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST);
  assign done_o    = en_i && w_at_last;

  // The count saturates at LAST so it never wraps if the owner lingers.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      r_count <= '0;
    end else if (en_i && !w_at_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/offchip_data_memory.sv
// -----------------------------------------------------------------------------
// offchip_data_memory
// Multi-cycle line memory behind the L1 data cache. Accepts one line request
// at a time and completes it LATENCY edges after acceptance with a single
// ack pulse. Inputs are ignored while a request is in flight.
//   clk_i : clock
//   rst_i : synchronous active-high reset; aborts any request in flight
//   bus   : slave side of offchip_data_memory_if (enable/write/addr/data in,
//           ack/data/busy out)
// Optional build macro DMEM_TRACE_EN: prints time, R/W, line index and line
// data at each completion edge (simulation only, no effect on logic).
// -----------------------------------------------------------------------------
module offchip_data_memory #(
  parameter int LINE_W  = dmem_pkg::LINE_W,
  parameter int DEPTH   = dmem_pkg::DEF_DEPTH,
  parameter int ADDR_W  = dmem_pkg::DEF_ADDR_W,
  parameter int LATENCY = dmem_pkg::DEF_LATENCY
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  offchip_data_memory_if.slave bus
);

  import dmem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_t       r_state;
  logic              r_ack;
  logic              r_busy;
  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_data_o;
  logic [LINE_W-1:0] r_mem [DEPTH];

  logic              w_start;
  logic              w_done;
  logic [IDX_W-1:0]  w_idx;
  logic              w_unused_addr;

  // Index field is a plain truncation of the address: aliasing is intended.
  assign w_idx         = bus.addr_i[OFFSET_BITS +: IDX_W];
  assign w_unused_addr = ^{bus.addr_i[OFFSET_BITS-1:0],
                           bus.addr_i[ADDR_W-1:OFFSET_BITS+IDX_W]};
  assign w_start       = (r_state == IDLE) && bus.enable_i;

  dmem_delay_counter #(
    .LATENCY (LATENCY)
  ) u_delay (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_start),
    .en_i    (r_state == WAIT),
    .done_o  (w_done)
  );

  // Request FSM with registered ack/busy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          if (bus.enable_i) begin
            r_state <= WAIT;
            r_busy  <= 1'b1;
            r_write <= bus.write_i;
            r_idx   <= w_idx;
            r_wdata <= bus.data_i;
          end
        end
        WAIT: begin
          if (w_done) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array write port: commits on the completion edge unless reset wins.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_done && r_write) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Registered read port; only read completions update the output line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data_o <= '0;
    end else if (w_done && !r_write) begin
      r_data_o <= r_mem[r_idx];
    end
  end

  assign bus.ack_o  = r_ack;
  assign bus.busy_o = r_busy;
  assign bus.data_o = r_data_o;

`ifdef DMEM_TRACE_EN
  always @(posedge clk_i) begin
    if (!rst_i && w_done) begin
      $display("%0t %s %0d %h", $time, r_write ? "W" : "R", r_idx,
               r_write ? r_wdata : r_mem[r_idx]);
    end
  end
`endif

endmodule

// File: tb/tb_offchip_data_memory.sv
// -----------------------------------------------------------------------------
// tb_offchip_data_memory
// Self-checking bench for offchip_data_memory. A request-level model predicts
// ack/busy/data_o from acceptance times; a negedge process compares every
// cycle. Directed scenarios add literal expectations on ack timing and data.
// -----------------------------------------------------------------------------
module tb_offchip_data_memory;

  localparam int L = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  offchip_data_memory_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  offchip_data_memory #(
    .LINE_W  (256),
    .DEPTH   (512),
    .ADDR_W  (32),
    .LATENCY (L)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int ack_log[$];

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_n, act, exp);
    end
  endfunction

  // ---------------- request-level model ----------------
  logic [255:0] m_mem [int];
  logic [255:0] m_data = '0;
  bit           m_live = 1'b0;
  int           m_t0 = -100;
  bit           m_wr;
  int           m_idx;
  logic [255:0] m_wd;
  bit           exp_ack = 1'b0;
  bit           exp_busy = 1'b0;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_live = 1'b0;
      m_data = '0;
    end else if (!m_live) begin
      if (bus.enable_i) begin
        m_live = 1'b1;
        m_t0   = edge_n;
        m_wr   = bus.write_i;
        m_idx  = int'(bus.addr_i[13:5]);
        m_wd   = bus.data_i;
      end
    end else begin
      if (edge_n == m_t0 + L) begin
        if (m_wr) m_mem[m_idx] = m_wd;
        else m_data = m_mem.exists(m_idx) ? m_mem[m_idx] : 'x;
      end
      if (edge_n == m_t0 + L + 1) m_live = 1'b0;
    end
    exp_busy = m_live;
    exp_ack  = m_live && (edge_n == m_t0 + L);
  end

  always @(negedge clk) begin
    if (edge_n > 0) begin
      chk("ack", bus.ack_o, exp_ack);
      chk("busy", bus.busy_o, exp_busy);
      chk("data_o", bus.data_o, m_data);
      if (bus.ack_o === 1'b1) ack_log.push_back(edge_n);
    end
  end

  // ---------------- stimulus helpers ----------------
  int pool[14] = '{1, 2, 3, 33, 64, 511, 100, 101, 102, 103, 104, 105, 106, 107};

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    a[13:5] = 9'(pool[$urandom_range(0, 13)]);
    return a;
  endfunction

  function automatic logic [255:0] pre_line(int idx);
    logic [31:0] w;
    w = 32'h1000_0000 + 32'(idx);
    return {8{w}};
  endfunction

  // Called just after a negedge with the DUT idle; returns just after the
  // negedge between edges T0+L+1 and T0+L+2, so the next request is accepted.
  task automatic do_req(input bit wr, input logic [31:0] addr,
                        input logic [255:0] data, output int t0);
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = addr;
    bus.data_i   = data;
    t0 = edge_n + 1;
    @(negedge clk);
    bus.enable_i = 1'b0;
    chk("busy_after_accept", bus.busy_o, 1'b1);
    repeat (L + 1) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    logic [31:0] a;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ack", bus.ack_o, 1'b0);
    chk("reset_busy", bus.busy_o, 1'b0);
    chk("reset_data", bus.data_o, 256'h0);
    rst = 1'b0;

    // Preload every line the bench will ever read.
    foreach (pool[i]) begin
      a = '0;
      a[13:5] = 9'(pool[i]);
      do_req(1'b1, a, pre_line(pool[i]), t0);
    end

    // 1: write line 33
    ack_log.delete();
    do_req(1'b1, 32'h0000_0420, {8{32'hDEAD_BEEF}}, t0);
    chk("t1_ack_count", 256'(ack_log.size()), 256'd1);
    chk("t1_ack_edge", 256'(ack_log[0]), 256'(t0 + 10));
    chk("t1_busy_low", bus.busy_o, 1'b0);

    // 2: read back via unaligned address in the same line
    ack_log.delete();
    do_req(1'b0, 32'h0000_043F, '0, t0);
    chk("t2_ack_edge", 256'(ack_log[0]), 256'(t0 + 10));
    chk("t2_data", bus.data_o, {8{32'hDEAD_BEEF}});
    repeat (2) @(negedge clk);
    chk("t2_data_held", bus.data_o, {8{32'hDEAD_BEEF}});

    // 3: second enable (write to line 64) while busy is ignored
    ack_log.delete();
    bus.enable_i = 1'b1; bus.write_i = 1'b0; bus.addr_i = 32'h0000_0420;
    t0 = edge_n + 1;
    @(negedge clk);
    bus.enable_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.enable_i = 1'b1; bus.write_i = 1'b1; bus.addr_i = 32'h0000_0800;
    bus.data_i = '0;
    @(negedge clk);
    bus.enable_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("t3_ack_count", 256'(ack_log.size()), 256'd1);
    chk("t3_ack_edge", 256'(ack_log[0]), 256'(t0 + 10));
    chk("t3_data", bus.data_o, {8{32'hDEAD_BEEF}});
    do_req(1'b0, 32'h0000_0800, '0, t0);
    chk("t3_line64", bus.data_o, {8{32'h1000_0040}});

    // 4: reset mid-write discards the write
    ack_log.delete();
    bus.enable_i = 1'b1; bus.write_i = 1'b1; bus.addr_i = 32'h0000_0020;
    bus.data_i = {32{8'hA5}};
    t0 = edge_n + 1;
    @(negedge clk);
    bus.enable_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_busy_after_rst", bus.busy_o, 1'b0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t4_no_ack", 256'(ack_log.size()), 256'd0);
    do_req(1'b0, 32'h0000_0020, '0, t0);
    chk("t4_line1", bus.data_o, {8{32'h1000_0001}});

    // 5: enable held high across reads of lines 2 and 3
    ack_log.delete();
    bus.enable_i = 1'b1; bus.write_i = 1'b0; bus.addr_i = 32'h0000_0040;
    t0 = edge_n + 1;
    @(negedge clk);
    bus.addr_i = 32'h0000_0060;
    repeat (12) @(negedge clk);
    bus.enable_i = 1'b0;
    repeat (11) @(negedge clk);
    chk("t5_ack_count", 256'(ack_log.size()), 256'd2);
    chk("t5_ack0", 256'(ack_log[0]), 256'(t0 + 10));
    chk("t5_ack1", 256'(ack_log[1]), 256'(t0 + 22));
    chk("t5_data", bus.data_o, {8{32'h1000_0003}});

    // 6: write line 511 then read it with no idle gap
    bus.enable_i = 1'b1; bus.write_i = 1'b1; bus.addr_i = 32'h0000_3FE0;
    bus.data_i = {8{32'h0000_0001}};
    @(negedge clk);
    bus.write_i = 1'b0;
    bus.data_i  = '0;
    repeat (12) @(negedge clk);
    bus.enable_i = 1'b0;
    repeat (11) @(negedge clk);
    chk("t6_data", bus.data_o, {8{32'h0000_0001}});

    // Random traffic with occasional resets; the model checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      bus.enable_i = ($urandom_range(0, 9) < 6);
      bus.write_i  = $urandom_range(0, 1);
      bus.addr_i   = rand_addr();
      bus.data_i   = rand_line();
      rst          = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.enable_i = 1'b0;
    repeat (L + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
